// File: rtl/video_grid_sampler_pkg.sv
// video_sampler_pkg: shared types and width helper for the video grid sampler
package video_sampler_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;
  function automatic int addr_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int DEF_ADDR_W = addr_w(16 * 8);
endpackage

// File: rtl/video_grid_sampler_if.sv
// video_grid_sampler_if: frame-buffer write port between the sampler (master) and the LED buffer (slave)
interface video_grid_sampler_if
  import video_sampler_pkg::*;
#(parameter int ADDR_W = DEF_ADDR_W);
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  modport master (output wr_en, wr_bank, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_bank, wr_addr, wr_data);
endinterface

// File: rtl/video_grid_sampler_phase_cnt.sv
// sampler_phase_cnt: phase counter 0..STEP-1 with a saturating cell index and centre-hit flag
module sampler_phase_cnt #(
  parameter int STEP  = 50,
  parameter int LIMIT = 16,
  localparam int IW   = $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic          sample_hit,
  output logic [IW-1:0] index
);
  localparam int PW = $clog2(STEP > 1 ? STEP : 2);
  logic [PW-1:0] phase;
  logic          wrap;
  assign wrap       = phase == PW'(STEP - 1);
  assign sample_hit = phase == PW'(STEP / 2) && index < IW'(LIMIT);
  // advance the phase per event; the index steps on wrap and sticks at LIMIT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase <= '0;
      index <= '0;
    end else begin
      phase <= clear ? '0 : advance ? (wrap ? '0 : phase + 1'b1) : phase;
      index <= clear ? '0 : (advance && wrap && index != IW'(LIMIT)) ? index + 1'b1 : index;
    end
endmodule

// File: rtl/video_grid_sampler.sv
// video_grid_sampler: decimates DE-framed RGB video to a COLS x ROWS grid of cell-centre samples (optional VIDEO_SAMPLER_TIMING_CHECK_EN adds timing measurement)
module video_grid_sampler
  import video_sampler_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int COLS     = 16,
  parameter int ROWS     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vid_vs,
  input  logic                 vid_hs,
  input  logic                 vid_de,
  input  logic [7:0]           vid_r,
  input  logic [7:0]           vid_g,
  input  logic [7:0]           vid_b,
  video_grid_sampler_if.master wr,
  output logic                 frame_done,
  output logic [15:0]          meas_h,
  output logic [15:0]          meas_v,
  output logic                 fmt_err
);
  localparam int H_STEP = H_ACTIVE / COLS;
  localparam int V_STEP = V_ACTIVE / ROWS;
  localparam int ADDR_W = addr_w(COLS * ROWS);
  localparam int CW     = $clog2(COLS * ROWS + 1);
  state_t                     state;
  logic                       s1_vs, s1_de, vs_d, de_d;
  rgb888_t                    s1_px;
  logic                       vs_rise, de_rise, de_fall, proc, h_hit, v_hit, wr_hit, done;
  logic [$clog2(COLS+1)-1:0]  h_idx;
  logic [$clog2(ROWS+1)-1:0]  v_idx;
  logic [CW-1:0]              wr_cnt;
  logic                       unused_hs;
  assign unused_hs = vid_hs;
  assign vs_rise   = s1_vs & ~vs_d;
  assign de_rise   = s1_de & ~de_d;
  assign de_fall   = ~s1_de & de_d;
  assign proc      = (state == ACTIVE || (state == ARMED && de_rise)) && !vs_rise;
  assign wr_hit    = proc & s1_de & h_hit & v_hit;
  assign done      = state == ACTIVE && vs_rise && wr_cnt == CW'(COLS * ROWS);
  sampler_phase_cnt #(.STEP(H_STEP), .LIMIT(COLS)) u_h (
    .clk, .rst_n, .clear(~proc | de_fall), .advance(proc & s1_de), .sample_hit(h_hit), .index(h_idx)
  );
  sampler_phase_cnt #(.STEP(V_STEP), .LIMIT(ROWS)) u_v (
    .clk, .rst_n, .clear(state != ACTIVE), .advance(state == ACTIVE && de_fall), .sample_hit(v_hit), .index(v_idx)
  );
  // input stage, frame FSM and registered write port / frame completion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      s1_vs      <= 1'b0;
      s1_de      <= 1'b0;
      s1_px      <= '0;
      vs_d       <= 1'b0;
      de_d       <= 1'b0;
      wr_cnt     <= '0;
      wr.wr_en   <= 1'b0;
      wr.wr_bank <= 1'b0;
      wr.wr_addr <= '0;
      wr.wr_data <= '0;
      frame_done <= 1'b0;
    end else begin
      s1_vs      <= vid_vs;
      s1_de      <= vid_de;
      s1_px      <= '{r: vid_r, g: vid_g, b: vid_b};
      vs_d       <= s1_vs;
      de_d       <= s1_de;
      state      <= vs_rise ? ARMED : (state == ARMED && de_rise) ? ACTIVE : state;
      wr_cnt     <= state != ACTIVE ? '0 : wr_cnt + CW'(wr_hit);
      wr.wr_en   <= wr_hit;
      wr.wr_addr <= wr_hit ? ADDR_W'(int'(v_idx) * COLS + int'(h_idx)) : wr.wr_addr;
      wr.wr_data <= wr_hit ? s1_px : wr.wr_data;
      frame_done <= done;
      wr.wr_bank <= wr.wr_bank ^ done;
    end
`ifdef VIDEO_SAMPLER_TIMING_CHECK_EN
  logic [15:0] h_cnt, v_cnt, v_tot;
  logic        bad, line_bad;
  assign line_bad = de_fall && h_cnt != 16'(H_ACTIVE);
  assign v_tot    = v_cnt + 16'(de_fall);
  // measure DE length per line and lines per frame, flag any deviation at frame end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      bad     <= 1'b0;
      meas_h  <= '0;
      meas_v  <= '0;
      fmt_err <= 1'b0;
    end else begin
      h_cnt   <= de_fall ? '0 : h_cnt + 16'(s1_de);
      meas_h  <= de_fall ? h_cnt : meas_h;
      v_cnt   <= vs_rise ? '0 : v_tot;
      meas_v  <= vs_rise ? v_tot : meas_v;
      fmt_err <= vs_rise ? (bad | line_bad | (v_tot != 16'(V_ACTIVE))) : fmt_err;
      bad     <= vs_rise ? 1'b0 : bad | line_bad;
    end
`else
  assign meas_h  = '0;
  assign meas_v  = '0;
  assign fmt_err = 1'b0;
`endif
endmodule

// File: tb/tb_video_grid_sampler.sv
// tb_video_grid_sampler: directed frames on a 64x16 raster decimated to 4x4; pixel = {x, y, x^y}
module tb_video_grid_sampler;
`ifdef VIDEO_SAMPLER_TIMING_CHECK_EN
  localparam bit TC = 1'b1;
`else
  localparam bit TC = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n, vs, hs, de;
  logic [7:0]  r, g, b;
  logic        frame_done, fmt_err;
  logic [15:0] meas_h, meas_v;
  logic [23:0] mem [16];
  int          cyc = 0, errors = 0, checks = 0;
  int          wcnt, fd_cnt, fd_cyc, vs_cyc, px_cyc, first_wr, maxx;
  bit          meas_nz = 1'b0;

  video_grid_sampler_if #(.ADDR_W(4)) wr ();

  video_grid_sampler #(.H_ACTIVE(64), .V_ACTIVE(16), .COLS(4), .ROWS(4)) dut (
    .clk(clk), .rst_n(rst_n), .vid_vs(vs), .vid_hs(hs), .vid_de(de),
    .vid_r(r), .vid_g(g), .vid_b(b), .wr(wr.master),
    .frame_done(frame_done), .meas_h(meas_h), .meas_v(meas_v), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr.wr_en === 1'b1) begin
      wcnt++;
      mem[wr.wr_addr] = wr.wr_data;
      if (first_wr < 0) first_wr = cyc;
      if (int'(wr.wr_data[23:16]) > maxx) maxx = int'(wr.wr_data[23:16]);
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (meas_h != 0 || meas_v != 0 || fmt_err !== 1'b0) meas_nz = 1'b1;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_px(int a);
    int x, y;
    x = 8 + 16 * (a % 4);
    y = 2 + 4 * (a / 4);
    return {8'(x), 8'(y), 8'(x ^ y)};
  endfunction

  task automatic clr();
    wcnt = 0;
    fd_cnt = 0;
    maxx = 0;
  endtask

  task automatic vsync();
    @(negedge clk);
    vs = 1'b1;
    vs_cyc = cyc;
    repeat (3) @(negedge clk);
    vs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic line(int y, int len);
    for (int x = 0; x < len; x++) begin
      @(negedge clk);
      de = 1'b1;
      hs = 1'b0;
      r = 8'(x);
      g = 8'(y);
      b = 8'(x ^ y);
      if (x == 8 && y == 2) px_cyc = cyc;
    end
    @(negedge clk);
    de = 1'b0;
    hs = 1'b1;
    {r, g, b} = '0;
    repeat (7) @(negedge clk);
  endtask

  task automatic frame(int nl, int odd_y, int odd_len, int rst_y);
    for (int y = 0; y < nl; y++) begin
      if (y == rst_y) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wr_en", 32'(wr.wr_en), 0);
        check("rst_mid_bank", 32'(wr.wr_bank), 0);
        check("rst_mid_addr", 32'(wr.wr_addr), 0);
        check("rst_mid_data", 32'(wr.wr_data), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clr();
      end
      line(y, y == odd_y ? odd_len : 64);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    {vs, hs, de, r, g, b} = '0;
    first_wr = -1;
    clr();
    repeat (3) @(negedge clk);
    check("reset_wr_en", 32'(wr.wr_en), 0);
    check("reset_bank", 32'(wr.wr_bank), 0);
    check("reset_addr", 32'(wr.wr_addr), 0);
    check("reset_data", 32'(wr.wr_data), 0);
    check("reset_frame_done", 32'(frame_done), 0);
    check("reset_meas_h", 32'(meas_h), 0);
    check("reset_meas_v", 32'(meas_v), 0);
    check("reset_fmt_err", 32'(fmt_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    vsync();
    check("first_vs_writes", 32'(wcnt), 0);
    check("first_vs_done", 32'(fd_cnt), 0);

    frame(16, -1, 0, -1);
    vsync();
    check("frameA_writes", 32'(wcnt), 16);
    check("frameA_done", 32'(fd_cnt), 1);
    check("frameA_bank", 32'(wr.wr_bank), 1);
    check("frameA_addr0", 32'(mem[0]), 32'h08020A);
    check("frameA_addr2", 32'(mem[2]), 32'h28022A);
    check("frameA_addr5", 32'(mem[5]), 32'h18061E);
    check("frameA_addr15", 32'(mem[15]), 32'h380E36);
    check("write_latency", 32'(first_wr - px_cyc), 2);
    check("done_latency", 32'(fd_cyc - vs_cyc), 2);

    clr();
    frame(16, -1, 0, 8);
    check("rst_rest_writes", 32'(wcnt), 0);
    vsync();
    check("rst_vs_writes", 32'(wcnt), 0);
    check("rst_vs_done", 32'(fd_cnt), 0);
    check("rst_vs_bank", 32'(wr.wr_bank), 0);

    for (int a = 0; a < 16; a++) mem[a] = '0;
    clr();
    frame(16, -1, 0, -1);
    vsync();
    check("frameB_writes", 32'(wcnt), 16);
    check("frameB_done", 32'(fd_cnt), 1);
    check("frameB_bank", 32'(wr.wr_bank), 1);
    for (int a = 0; a < 16; a++) check($sformatf("frameB_mem%0d", a), 32'(mem[a]), 32'(exp_px(a)));

    clr();
    frame(8, -1, 0, -1);
    vsync();
    check("short_writes", 32'(wcnt), 8);
    check("short_done", 32'(fd_cnt), 0);
    check("short_bank", 32'(wr.wr_bank), 1);

    clr();
    frame(16, 2, 90, -1);
    vsync();
    check("long_writes", 32'(wcnt), 16);
    check("long_max_x", 32'(maxx), 32'h38);
    check("long_done", 32'(fd_cnt), 1);
    check("long_bank", 32'(wr.wr_bank), 0);

    clr();
    frame(16, 15, 63, -1);
    check("tc_meas_h_short", 32'(meas_h), TC ? 63 : 0);
    vsync();
    check("tc_meas_v", 32'(meas_v), TC ? 16 : 0);
    check("tc_fmt_err_set", 32'(fmt_err), TC ? 1 : 0);
    check("tc_done_ungated", 32'(fd_cnt), 1);
    check("tc_bank", 32'(wr.wr_bank), 1);

    clr();
    frame(16, -1, 0, -1);
    vsync();
    check("tc_fmt_err_clear", 32'(fmt_err), 0);
    check("tc_meas_h_clean", 32'(meas_h), TC ? 64 : 0);
    check("clean_bank", 32'(wr.wr_bank), 0);
    check("meas_activity", 32'(meas_nz), TC ? 1 : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
